// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: program control, ROM port and instruction handshake.
interface instr_fetch_if;
  localparam int unsigned W = 8;

  logic         start;
  logic [W-1:0] noi;
  logic         done;
  logic [W-1:0] rom_data;
  logic [W-1:0] rom_addr;
  logic         rom_set_addr;
  logic         rom_en_data;
  logic [W-1:0] ir_op;
  logic [W-1:0] ir_imm;
  logic         two_byte;
  logic [W-1:0] pc_out;
  logic         instr_valid;
  logic         instr_ready;
  logic         branch_en;
  logic [W-1:0] branch_addr;

  // Fetch unit side
  modport master (
    input  start, noi, rom_data, instr_ready, branch_en, branch_addr,
    output done, rom_addr, rom_set_addr, rom_en_data,
           ir_op, ir_imm, two_byte, pc_out, instr_valid
  );

  // Environment side: ROM, sequencer and instruction consumer
  modport slave (
    output start, noi, rom_data, instr_ready, branch_en, branch_addr,
    input  done, rom_addr, rom_set_addr, rom_en_data,
           ir_op, ir_imm, two_byte, pc_out, instr_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: reads one- or two-byte instructions from a byte ROM
// and hands them to a consumer over a valid/ready handshake.
module instr_fetch (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    IDLE, ADDR_OP, READ_OP, ADDR_IMM, READ_IMM, VALID, DONE
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic         op_two_byte_c;

  // Opcode classes 001x_xxxx and 010x_xxxx carry an immediate byte
  assign op_two_byte_c = (bus.rom_data[7:5] == 3'b001) || (bus.rom_data[7:5] == 3'b010);

  // Next-state and next-pc logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = (bus.noi == '0) ? DONE : ADDR_OP;
        end
      end
      ADDR_OP:  state_d = READ_OP;
      READ_OP: begin
        pc_d    = pc_q + W'(1);
        state_d = op_two_byte_c ? ADDR_IMM : VALID;
      end
      ADDR_IMM: state_d = READ_IMM;
      READ_IMM: begin
        pc_d    = pc_q + W'(1);
        state_d = VALID;
      end
      VALID: begin
        if (bus.instr_ready) begin
          if (bus.branch_en) pc_d = bus.branch_addr;
          state_d = (pc_d >= bus.noi) ? DONE : ADDR_OP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pc and registered outputs decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      pc_q             <= '0;
      bus.rom_addr     <= '0;
      bus.rom_set_addr <= 1'b0;
      bus.rom_en_data  <= 1'b0;
      bus.ir_op        <= '0;
      bus.ir_imm       <= '0;
      bus.two_byte     <= 1'b0;
      bus.pc_out       <= '0;
      bus.instr_valid  <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      bus.rom_set_addr <= (state_d == ADDR_OP) || (state_d == ADDR_IMM);
      bus.rom_en_data  <= (state_d == READ_OP) || (state_d == READ_IMM);
      bus.instr_valid  <= (state_d == VALID);
      bus.done         <= (state_d == DONE);
      if ((state_d == ADDR_OP) || (state_d == ADDR_IMM)) bus.rom_addr <= pc_d;
      if (state_q == READ_OP) begin
        bus.ir_op    <= bus.rom_data;
        bus.ir_imm   <= '0;
        bus.two_byte <= op_two_byte_c;
        bus.pc_out   <= pc_q;
      end
      if (state_q == READ_IMM) bus.ir_imm <= bus.rom_data;
    end
  end
endmodule
